// File: rtl/sc2bin_counter.sv
// Bipolar stochastic-to-binary converter: counts ones over 2^LOG_LEN valid bits
// and emits a saturated signed BITWIDTH-bit result with a one-cycle valid pulse.
module sc2bin_counter #(
  parameter int BITWIDTH = 8,
  parameter int LOG_LEN  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                sc_in,
  input  logic                sc_valid,
  output logic                busy,
  output logic [BITWIDTH-1:0] bin_out,
  output logic                bin_valid
);

  localparam int L  = 1 << LOG_LEN;
  localparam int S  = LOG_LEN - (BITWIDTH - 1);
  localparam int CW = LOG_LEN + 1;
  localparam int VW = LOG_LEN + 2;
  localparam logic signed [VW-1:0] MAX_V = VW'((1 << (BITWIDTH - 1)) - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // Handshake: start is accepted only in IDLE; sc_in is consumed on every ACCUM
  // edge where sc_valid=1; bin_valid pulses for one cycle when bin_out updates.
  state_t              state_q, state_d;
  logic [CW-1:0]       bit_q, bit_d, ones_q, ones_d, ones_inc;
  logic [BITWIDTH-1:0] bin_q, bin_d;
  logic                valid_q, valid_d;
  logic                last_bit;
  logic signed [VW-1:0] v, vs, sat;

  assign ones_inc = ones_q + CW'(sc_in);
  assign last_bit = (bit_q == CW'(L - 1));

  // v = 2c - L, floor-shifted down to BITWIDTH range; only +2^(BITWIDTH-1) can overflow.
  always_comb begin
    v   = $signed({ones_inc, 1'b0} - VW'(L));
    vs  = v >>> S;
    sat = (vs > MAX_V) ? MAX_V : vs;
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ones_d  = ones_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ACCUM;
          bit_d   = '0;
          ones_d  = '0;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_d = IDLE;
          bit_d   = '0;
          ones_d  = '0;
        end else if (sc_valid) begin
          bit_d  = bit_q + CW'(1);
          ones_d = ones_inc;
          if (last_bit) begin
            state_d = IDLE;
            bin_d   = sat[BITWIDTH-1:0];
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      ones_q  <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ones_q  <= ones_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = (state_q == ACCUM);
  assign bin_out   = bin_q;
  assign bin_valid = valid_q;

endmodule

// File: tb/tb_sc2bin_counter.sv
// Scoreboard bench for sc2bin_counter: expected results queued at stimulus time,
// popped and compared whenever bin_valid pulses.
module tb_sc2bin_counter;

  localparam int BW  = 8;
  localparam int LL  = 8;
  localparam int L   = 1 << LL;
  localparam int S   = LL - (BW - 1);
  localparam int MAXV = (1 << (BW - 1)) - 1;
  localparam int MINV = -(1 << (BW - 1));

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sc_in = 1'b0;
  logic          sc_valid = 1'b0;
  logic          busy;
  logic [BW-1:0] bin_out;
  logic          bin_valid;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] held = '0;
  int            n_vec = 0;
  int            n_err = 0;

  sc2bin_counter #(.BITWIDTH(BW), .LOG_LEN(LL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .sc_in(sc_in), .sc_valid(sc_valid), .busy(busy),
    .bin_out(bin_out), .bin_valid(bin_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] model(input int c);
    int v;
    v = 2 * c - L;
    v = v >>> S;
    if (v > MAXV) v = MAXV;
    if (v < MINV) v = MINV;
    return BW'(v);
  endfunction

  function automatic bit pat(input int mode, input int k, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 2 == 0);
      default: return (i < k);
    endcase
  endfunction

  // scoreboard consumer
  always @(negedge clk) begin
    if (bin_valid) begin
      if (exp_q.size() == 0) check("spurious_pulse", 32'(bin_valid), 32'd0);
      else check("bin_out_sb", 32'(bin_out), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on_start", 32'(busy), 32'd1);
    check("valid_low", 32'(bin_valid), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("valid_drop", 32'(bin_valid), 32'd0);
    end
  endtask

  task automatic feed(input int mode, input int k, input int n, input bit gaps,
                      input bit abort_last, input bit start_mid);
    int ones;
    int bcnt;
    int edges;
    bit b;
    ones = 0; bcnt = 0; edges = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        sc_valid = 1'b0; sc_in = 1'b1;
        bcnt += int'(busy); edges++;
        @(posedge clk); #1;
      end
      b = pat(mode, k, i);
      ones += int'(b);
      sc_valid = 1'b1; sc_in = b;
      if (start_mid && i == 50) start = 1'b1;
      if (abort_last && i == n - 1) abort = 1'b1;
      if (i == L - 1 && !abort_last) begin
        held = model(ones);
        exp_q.push_back(held);
      end
      bcnt += int'(busy); edges++;
      @(posedge clk); #1;
      sc_valid = 1'b0; sc_in = 1'b0; start = 1'b0; abort = 1'b0;
    end
    check("busy_cycles", 32'(bcnt), 32'(edges));
    if (n == L) check("busy_after_last", 32'(busy), 32'd0);
    if (n == L && !abort_last) begin
      check("valid_pulse", 32'(bin_valid), 32'd1);
      check("bin_out_now", 32'(bin_out), 32'(held));
    end
    if (abort_last) check("no_pulse_abort", 32'(bin_valid), 32'd0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bsum;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bin_valid), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    #20 reset_n = 1'b1;
    @(posedge clk); #1;

    do_start(); feed(0, 0, L, 0, 0, 0); idle(2);            // all ones -> 127
    do_start(); feed(1, 0, L, 0, 0, 0); idle(2);            // all zeros -> -128
    do_start(); feed(2, 0, L, 0, 0, 0); idle(2);            // alternating -> 0
    do_start(); feed(3, 192, L, 1, 0, 0); idle(2);          // gapped, 192 ones -> 64

    do_start(); feed(0, 0, 100, 0, 0, 0);                   // abort after 100 bits
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("busy_abort", 32'(busy), 32'd0);
    idle(4);
    check("held_after_abort", 32'(bin_out), 32'(held));

    do_start(); feed(3, 64, L, 0, 0, 0); idle(2);           // 64 ones -> -64
    do_start(); feed(0, 0, L, 0, 1, 0); idle(3);            // abort on final bit
    check("held_after_abort_last", 32'(bin_out), 32'(held));

    do_start(); feed(2, 0, L, 0, 0, 1);                     // start mid-ACCUM ignored
    do_start(); feed(3, 192, L, 0, 0, 0); idle(2);          // back-to-back start

    start = 1'b1; abort = 1'b1;                             // abort beats start in IDLE
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_over_start", 32'(busy), 32'd0);

    do_start(); feed(0, 0, 150, 0, 0, 0);                   // async reset mid-conversion
    #2 reset_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_valid", 32'(bin_valid), 32'd0);
    check("areset_bin_out", 32'(bin_out), 32'd0);
    held = '0;
    @(posedge clk); #3 reset_n = 1'b1;
    bsum = 0;
    for (int i = 0; i < 300; i++) begin
      sc_valid = 1'b1; sc_in = 1'(($urandom_range(0, 3) != 0));
      @(posedge clk); #1;
      bsum += int'(busy);
    end
    sc_valid = 1'b0;
    check("no_start_busy", 32'(bsum), 32'd0);
    idle(2);
    check("bin_out_post_reset", 32'(bin_out), 32'(held));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sc2bin_counter.md
# sc2bin_counter

Stochastic-to-binary converter feeding the ReLU activation stage. Counts the ones in a bipolar stochastic bitstream over a fixed window of 2^LOG_LEN valid bits and converts the count to a signed two's-complement value of BITWIDTH bits. It then presents that value with a one-cycle valid pulse. `bin_out` connects to the ReLU `relu_in`, and `bin_valid` connects to its `act_en`.

## Interface
- BITWIDTH, 8: width of signed binary output.
- LOG_LEN, 8: log2 of stream window length L = 2^LOG_LEN. Legal range is LOG_LEN >= BITWIDTH-1; other values are illegal.
- clk  input  1: clock; all state updates on rising edge.
- reset_n  input  1: asynchronous, active-low reset.
- start  input  1: begin a new conversion; sampled only in IDLE.
- abort  input  1: synchronous cancel of an in-progress conversion.
- sc_in  input  1: stochastic bit; 1 = +1, 0 = -1 (bipolar).
- sc_valid  input  1: qualifies sc_in; bits with sc_valid=0 are ignored.
- busy  output  1: high while in ACCUM.
- bin_out  output  BITWIDTH: signed result; holds its value until the next completed conversion.
- bin_valid  output  1: single-cycle pulse when bin_out updates.

## Operation
- FSM states are IDLE and ACCUM. Reset state is IDLE.
- IDLE:
  - start=1 → ACCUM; ones counter and bit counter cleared to 0.
  - sc_in and sc_valid are ignored.
- ACCUM, each cycle with sc_valid=1:
  - bit counter += 1.
  - ones counter += sc_in.
- Counter widths: both counters are LOG_LEN+1 bits, so the count L is representable without overflow.
- Completion: when the accepted bit is the L-th valid bit, on the same edge:
  - state → IDLE.
  - bin_out ← result.
  - bin_valid ← 1 for exactly one cycle.
- Result arithmetic, with c = ones count (0..L):
  - v = 2c − L, signed, LOG_LEN+2 bits, range [−L, +L].
  - Arithmetic shift right by S = LOG_LEN − (BITWIDTH−1), flooring toward −inf.
  - Saturate to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1]. Only +2^(BITWIDTH−1) can exceed the range, and it clips to max.
  - Defaults (BITWIDTH=8, LOG_LEN=8): bin_out = clip(c − 128, −128, 127).
- start while in ACCUM is ignored; the current conversion continues.
- abort=1 in ACCUM:
  - state → IDLE, counters cleared.
  - No bin_valid pulse; bin_out unchanged.
  - Simultaneous abort and final valid bit: abort wins, no pulse.
- abort=1 in IDLE has no effect, and abort takes priority over start in the same cycle.

## Timing
- Reset values (asynchronous, immediate on reset_n=0): state IDLE, busy 0, bin_valid 0, bin_out 0, both counters 0.
- Reset mid-conversion discards the partial count. No pulse occurs after release, and a fresh start is required.
- Start acceptance:
  - start high at edge t → busy=1 from t+1.
  - The first bit that can be accepted is at edge t+1.
- Completion timing:
  - Final valid bit sampled at edge t → bin_valid=1, busy=0, new bin_out visible during the cycle after t.
  - bin_valid drops after one cycle.
  - Latency from last valid bit to bin_valid is 1 cycle.
- Minimum conversion length is L cycles of ACCUM (sc_valid held high). Gaps in sc_valid extend it 1:1.
- Back-to-back conversions:
  - The cycle carrying bin_valid=1 is an IDLE cycle, so start is accepted there.
  - Minimum period is L+1 cycles per conversion.

## Test plan
- All ones, L=256 bits with sc_valid always 1 → bin_out=127 (saturated), bin_valid high exactly 1 cycle, asserted 1 cycle after the 256th bit; busy high for 256 cycles.
- All zeros, 256 bits → bin_out=0x80 (−128); alternating 1/0, 256 bits → bin_out=0.
- 192 ones + 64 zeros with sc_valid toggling every cycle (512 ACCUM cycles) → bin_out=64 (0x40); invalid-cycle sc_in values set to 1 must not count.
- Start, 100 bits, then abort → no bin_valid, bin_out keeps prior value. Then start with 64 ones + 192 zeros → bin_out=0xC0 (−64). Repeat with abort on the 256th bit → no pulse.
- Start pulsed again during ACCUM → ignored, result unchanged. Start asserted in the bin_valid cycle → next conversion begins, with busy high on the following cycle.
- reset_n low after 150 bits → busy, bin_valid and bin_out go to 0 asynchronously. After release, bits with no start produce no pulse.
